// File: rtl/phase_ctrl_unit.sv
// rtl/phase_ctrl_unit.sv - multicycle control sequencer driven by the one-hot five-phase bus
// Decodes the latched instruction into per-phase datapath enables, retires, halts, traps bad phase order.
module phase_ctrl_unit #(
  parameter int          DATA_W  = 32,
  parameter int          CNT_W   = 16,
  parameter logic [5:0]  OP_LW   = 6'h23,
  parameter logic [5:0]  OP_SW   = 6'h2B,
  parameter logic [5:0]  OP_HALT = 6'h3F
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [4:0]        Phases,
  input  logic [DATA_W-1:0] Instr,
  input  logic              HaltReq,
  output logic [DATA_W-1:0] IR,
  output logic              IREn,
  output logic              RegRdEn,
  output logic              AluEn,
  output logic              MemRdEn,
  output logic              MemWrEn,
  output logic              RegWrEn,
  output logic              PCEn,
  output logic [CNT_W-1:0]  RetireCount,
  output logic              Busy,
  output logic              Halted,
  output logic              PhaseErr
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic [1:0] state;
  logic [2:0] exp_idx;
  logic       halt_pend;
  logic [5:0] opcode;
  logic       phase_ok;
  logic       active;
  logic       end_p4;
  logic       is_lw;
  logic       is_sw;
  logic       is_halt;
  logic       is_r;

  always_comb begin
    opcode   = IR[DATA_W-1 -: 6];
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_halt  = (opcode == OP_HALT);
    is_r     = (opcode == 6'h00);
    phase_ok = (Phases == (5'b00001 << exp_idx));
    // A phase value out of sequence gates every enable in the very cycle it appears.
    active   = (state == S_RUN) && phase_ok;
    end_p4   = active && Phases[4];
  end

  always_comb begin
    IREn     = active && Phases[0];
    RegRdEn  = active && Phases[1];
    AluEn    = active && Phases[2];
    MemRdEn  = active && Phases[3] && is_lw;
    MemWrEn  = active && Phases[3] && is_sw;
    RegWrEn  = active && Phases[4] && (is_r || is_lw);
    PCEn     = active && Phases[4] && !is_halt;
    Busy     = (state == S_RUN);
    Halted   = (state == S_HALTED);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      IR          <= '0;
      RetireCount <= '0;
      PhaseErr    <= 1'b0;
      halt_pend   <= 1'b0;
      exp_idx     <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (HaltReq) begin
            state <= S_HALTED;
          end else if (Phases == 5'b10000) begin
            state     <= S_RUN;
            exp_idx   <= 3'd0;
            halt_pend <= 1'b0;
          end
        end
        S_RUN: begin
          if (!phase_ok) begin
            state    <= S_ERROR;
            PhaseErr <= 1'b1;
          end else begin
            if (Phases[0]) IR <= Instr;
            exp_idx <= (exp_idx == 3'd4) ? 3'd0 : exp_idx + 3'd1;
            if (end_p4) begin
              RetireCount <= RetireCount + CNT_W'(1);
              if (is_halt || halt_pend || HaltReq) state <= S_HALTED;
            end else if (HaltReq) begin
              // Deferred so the instruction in flight still reaches writeback.
              halt_pend <= 1'b1;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_ctrl_unit.sv
// tb/tb_phase_ctrl_unit.sv - directed self-checking bench for phase_ctrl_unit
module tb_phase_ctrl_unit;

  localparam logic [31:0] I_R    = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C43_0004;
  localparam logic [31:0] I_SW   = 32'hAC43_0008;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;
  localparam logic [31:0] I_GARB = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  Phases = 5'b0;
  logic [31:0] Instr = 32'b0;
  logic        HaltReq = 1'b0;

  logic [31:0] IR, IR_b;
  logic        IREn, RegRdEn, AluEn, MemRdEn, MemWrEn, RegWrEn, PCEn;
  logic        IREn_b, RegRdEn_b, AluEn_b, MemRdEn_b, MemWrEn_b, RegWrEn_b, PCEn_b;
  logic [15:0] RetireCount;
  logic [1:0]  RetireCount_b;
  logic        Busy, Halted, PhaseErr, Busy_b, Halted_b, PhaseErr_b;

  int checks = 0;
  int errors = 0;

  wire [6:0] en_a = {IREn, RegRdEn, AluEn, MemRdEn, MemWrEn, RegWrEn, PCEn};
  wire [6:0] en_b = {IREn_b, RegRdEn_b, AluEn_b, MemRdEn_b, MemWrEn_b, RegWrEn_b, PCEn_b};
  wire [5:0] st_ab = {Busy, Halted, PhaseErr, Busy_b, Halted_b, PhaseErr_b};

  phase_ctrl_unit dut (
    .CLK(CLK), .RST(RST), .Phases(Phases), .Instr(Instr), .HaltReq(HaltReq),
    .IR(IR), .IREn(IREn), .RegRdEn(RegRdEn), .AluEn(AluEn), .MemRdEn(MemRdEn),
    .MemWrEn(MemWrEn), .RegWrEn(RegWrEn), .PCEn(PCEn), .RetireCount(RetireCount),
    .Busy(Busy), .Halted(Halted), .PhaseErr(PhaseErr)
  );

  phase_ctrl_unit #(.CNT_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .Phases(Phases), .Instr(Instr), .HaltReq(HaltReq),
    .IR(IR_b), .IREn(IREn_b), .RegRdEn(RegRdEn_b), .AluEn(AluEn_b), .MemRdEn(MemRdEn_b),
    .MemWrEn(MemWrEn_b), .RegWrEn(RegWrEn_b), .PCEn(PCEn_b), .RetireCount(RetireCount_b),
    .Busy(Busy_b), .Halted(Halted_b), .PhaseErr(PhaseErr_b)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: let the previous inputs land on the edge, drive new ones, sample at the falling edge.
  task automatic cyc(input logic rst, input logic [4:0] ph, input logic [31:0] ins, input logic hr);
    @(posedge CLK);
    #1;
    RST = rst; Phases = ph; Instr = ins; HaltReq = hr;
    @(negedge CLK);
  endtask

  task automatic reset_and_start();
    cyc(1'b0, 5'b0, 32'b0, 1'b0);
    cyc(1'b0, 5'b0, 32'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      cyc(1'b1, 5'(1 << p), I_GARB, 1'b0);
      if (p == 0)
        check("reset_state", {IR, RetireCount, RetireCount_b, st_ab, en_a, en_b}, 64'h0);
      else
        check($sformatf("idle_p%0d", p), {st_ab, en_a, en_b}, 64'h0);
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input logic rd, input logic wr,
                           input logic rw, input logic pc, input int hr_at, input int cnt0);
    for (int p = 0; p < 5; p++) begin
      logic [6:0] want;
      cyc(1'b1, 5'(1 << p), (p == 0) ? ins : I_GARB, (p == hr_at));
      case (p)
        0:       want = 7'b1000000;
        1:       want = 7'b0100000;
        2:       want = 7'b0010000;
        3:       want = {3'b000, rd, wr, 2'b00};
        default: want = {5'b00000, rw, pc};
      endcase
      check($sformatf("en_p%0d_%h", p, ins), {en_a, en_b}, {want, want});
      if (p == 1) begin
        check("ir", {IR, IR_b}, {ins, ins});
        check("count", {RetireCount, RetireCount_b}, {16'(cnt0), 2'(cnt0)});
        check("busy", st_ab, 6'b100100);
      end
    end
  endtask

  initial begin
    // R-type stream, then LW, SW and a HALT instruction.
    reset_and_start();
    run_instr(I_R,    1'b0, 1'b0, 1'b1, 1'b1, 9, 0);
    run_instr(I_R,    1'b0, 1'b0, 1'b1, 1'b1, 9, 1);
    run_instr(I_R,    1'b0, 1'b0, 1'b1, 1'b1, 9, 2);
    run_instr(I_LW,   1'b1, 1'b0, 1'b1, 1'b1, 9, 3);
    run_instr(I_SW,   1'b0, 1'b1, 1'b0, 1'b1, 9, 4);
    run_instr(I_HALT, 1'b0, 1'b0, 1'b0, 1'b0, 9, 5);
    cyc(1'b1, 5'b00001, I_R, 1'b0);
    check("halt_state", st_ab, 6'b010010);
    check("halt_count", {RetireCount, RetireCount_b}, {16'd6, 2'd2});
    for (int i = 1; i < 21; i++) begin
      cyc(1'b1, 5'(1 << (i % 5)), I_R, 1'b0);
      check("halted_quiet", {st_ab, en_a, en_b}, {6'b010010, 14'h0});
    end

    // HaltReq pulse during decode: the instruction still completes.
    reset_and_start();
    run_instr(I_R, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0);
    cyc(1'b1, 5'b00001, I_R, 1'b0);
    check("haltreq_state", {st_ab, en_a, en_b}, {6'b010010, 14'h0});
    check("haltreq_count", {RetireCount, RetireCount_b}, {16'd1, 2'd1});

    // Out-of-order phase value.
    reset_and_start();
    run_instr(I_R, 1'b0, 1'b0, 1'b1, 1'b1, 9, 0);
    cyc(1'b1, 5'b00001, I_R, 1'b0);
    check("err_pre_fetch", {en_a, en_b}, {7'b1000000, 7'b1000000});
    cyc(1'b1, 5'b00110, I_GARB, 1'b0);
    check("err_same_cycle", {st_ab, en_a, en_b}, {6'b100100, 14'h0});
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 5'(1 << ((i + 2) % 5)), I_GARB, 1'b0);
      check("err_sticky", {st_ab, en_a, en_b}, {6'b001001, 14'h0});
    end
    cyc(1'b0, 5'b0, 32'b0, 1'b0);
    cyc(1'b1, 5'b00001, I_GARB, 1'b0);
    check("err_cleared", {st_ab, en_a, en_b}, 64'h0);

    // HaltReq while idle.
    cyc(1'b1, 5'b00010, I_GARB, 1'b1);
    cyc(1'b1, 5'b00100, I_GARB, 1'b0);
    check("idle_halt", {st_ab, en_a, en_b}, {6'b010010, 14'h0});

    // Counter wrap on the narrow instance, then reset in the middle of execute.
    reset_and_start();
    for (int k = 0; k < 5; k++) run_instr(I_R, 1'b0, 1'b0, 1'b1, 1'b1, 9, k);
    cyc(1'b1, 5'b00001, I_R, 1'b0);
    check("wrap_count", {RetireCount, RetireCount_b}, {16'd5, 2'd1});
    cyc(1'b1, 5'b00010, I_GARB, 1'b0);
    cyc(1'b0, 5'b00100, I_GARB, 1'b0);
    check("pre_reset_alu", {en_a, en_b}, {7'b0010000, 7'b0010000});
    cyc(1'b1, 5'b01000, I_GARB, 1'b0);
    check("mid_reset", {IR, RetireCount, RetireCount_b, st_ab, en_a, en_b}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
